branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Decodes RV32I branch funct3 internally, so the unsigned-compare select is derived rather than supplied by the caller.
- Evaluates the condition and registers the result in one pipeline stage with valid, stall and flush control.
- Flags a mispredict against the front-end prediction. Sits at the EX/MEM boundary of the 5-stage core and feeds PC-redirect and flush logic.

Parameters:
- XLEN, 32, operand width in bits (≥2).
- CNT_W, 32, width of each performance counter; used only when BRU_PERF_CNT_EN is defined.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and control on this cycle are live.
- is_branch  input  1  instruction is a conditional branch.
- funct3  input  3  branch funct3 field.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- pred_taken  input  1  front-end predicted taken.
- stall  input  1  hold the output stage.
- flush  input  1  kill the in-flight result.
- out_valid  output  1  registered result valid.
- eq  output  1  registered a==b.
- lt  output  1  registered a<b (signedness per funct3).
- taken  output  1  registered branch outcome.
- mispredict  output  1  registered taken≠prediction.
- illegal  output  1  registered: is_branch with funct3 010/011.

Behaviour:
- Reset: every output register is 0 (out_valid, eq, lt, taken, mispredict, illegal); counters are 0.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Edge update priority, highest first:
  - rst: clear everything.
  - flush: out_valid←0; other output registers may hold; counters unchanged.
  - stall: all output registers hold; inputs are ignored and lost (upstream must also stall).
  - Otherwise load: out_valid←in_valid, then compute the remaining outputs from the current inputs.
- Compare:
  - eq = (a==b), independent of funct3.
  - Unsigned select = funct3[1]. lt = unsigned compare when funct3[1]=1, else signed two's-complement compare over the full XLEN.
- Condition decode, when is_branch=1:
  - 000 BEQ: taken=eq.
  - 001 BNE: taken=!eq.
  - 100 BLT / 110 BLTU: taken=lt.
  - 101 BGE / 111 BGEU: taken=!lt.
  - 010 / 011: taken=0, illegal=1.
- When is_branch=0: taken=0, illegal=0.
- Mispredict: mispredict = in_valid & (taken ^ pred_taken), computed at load time. A non-branch predicted taken therefore flags a mispredict.
- When in_valid=0 at load: out_valid=0, taken=0, mispredict=0, illegal=0; eq/lt are don't-care but deterministic (computed from the inputs).
- Boundaries:
  - Extreme operands must compare correctly: a=0x8000_0000 vs b=0x7FFF_FFFF, and all-ones vs 0, in both signed and unsigned modes.
  - stall and flush asserted together: flush wins.
  - Reset asserted mid-stall: clears everything.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined, adds these ports:
  - clr_cnt input 1: synchronous counter clear, below rst and above increment.
  - br_cnt output CNT_W: number of loads with in_valid&is_branch.
  - mis_cnt output CNT_W: number of loads with mispredict computed as 1.
- Counter rules:
  - Counters increment only on a load edge; never on stall, flush or reset edges.
  - Each counter saturates at all-ones and does not wrap.
  - Both counters reset to 0.
- When undefined: the ports and counter logic are absent and behaviour is otherwise identical.

Decomposition:
- Package bru_pkg holds:
  - enum br_funct3_e (BEQ=3'b000, BNE=3'b001, BLT=3'b100, BGE=3'b101, BLTU=3'b110, BGEU=3'b111).
  - Default XLEN localparam.
  - Typedef br_result_t, a packed struct {eq, lt, taken, mispredict, illegal} used as the output-stage register.
- One combinational sub-module, branch_cond: parametrised on XLEN; takes a, b, funct3, is_branch; produces eq, lt, taken, illegal. The top level adds the pipeline register, control priority, mispredict and counters.

Test Plan:
- BLT/BLTU split: a=0xFFFF_FFFF, b=0x0000_0001, in_valid=1, is_branch=1, pred_taken=0. funct3=100 → next cycle taken=1, mispredict=1. funct3=110 → taken=0, mispredict=0.
- BGE equality plus mispredict: a=b=0x1234_5678, funct3=101, pred_taken=0 → eq=1, taken=1, mispredict=1. Same operands with funct3=001 and pred_taken=1 → taken=0, mispredict=1.
- Stall/flush priority: load a BEQ that is taken, then assert stall for 3 cycles with new inputs applied → outputs hold. Then assert stall=1 and flush=1 → out_valid=0 after that edge.
- Illegal and non-branch: is_branch=1, funct3=010 → illegal=1, taken=0. is_branch=0, pred_taken=1 → taken=0, mispredict=1, illegal=0.
- Reset mid-stream: after a valid taken result, assert rst for 1 cycle with stall=1 → all outputs 0 next cycle (and counters 0 under BRU_PERF_CNT_EN).
- BRU_PERF_CNT_EN, CNT_W=2: issue 5 valid mispredicting branches with one stalled cycle between them → br_cnt=3 and mis_cnt=3 (saturated). Then clr_cnt=1 → both 0.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit.
// Contents:
//   br_funct3_e  - RV32I conditional-branch funct3 encodings
//   XLEN_DEFAULT - default operand width
//   br_result_t  - registered per-instruction result record
package bru_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic taken;
    logic mispredict;
    logic illegal;
  } br_result_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator.
// Ports:
//   a, b      in  [XLEN-1:0] rs1 / rs2 operands
//   funct3    in  [2:0]      branch funct3 field
//   is_branch in             instruction is a conditional branch
//   eq        out            a == b, regardless of funct3
//   lt        out            a < b, unsigned when funct3[1] is set
//   taken     out            decoded branch outcome
//   illegal   out            is_branch with a reserved funct3 (010/011)
module branch_cond
  import bru_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  output logic            eq,
  output logic            lt,
  output logic            taken,
  output logic            illegal
);

  // funct3[1] separates the unsigned pair (BLTU/BGEU) from the signed
  // pair, so the compare select comes straight from the encoding.
  always_comb begin
    eq      = (a == b);
    lt      = funct3[1] ? (a < b) : ($signed(a) < $signed(b));
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_branch) begin
      case (funct3)
        BEQ:         taken = eq;
        BNE:         taken = !eq;
        BLT, BLTU:   taken = lt;
        BGE, BGEU:   taken = !lt;
        default:     illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit for the EX/MEM boundary: evaluates the branch
// condition, registers it in one stage and flags mispredicts.
// Optional feature macro: BRU_PERF_CNT_EN (branch / mispredict counters).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        inputs on this cycle are live
//   is_branch       instruction is a conditional branch
//   funct3 [2:0]    branch funct3 field
//   a, b [XLEN-1:0] operands
//   pred_taken      front-end prediction
//   stall           hold the output stage (inputs are dropped)
//   flush           kill the in-flight result
//   clr_cnt         (BRU_PERF_CNT_EN) clear counters
//   br_cnt, mis_cnt (BRU_PERF_CNT_EN) saturating event counters [CNT_W-1:0]
//   out_valid, eq, lt, taken, mispredict, illegal  registered results
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             is_branch,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic             pred_taken,
  input  logic             stall,
  input  logic             flush,
`ifdef BRU_PERF_CNT_EN
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt,
`endif
  output logic             out_valid,
  output logic             eq,
  output logic             lt,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal
);

  logic       cond_eq;
  logic       cond_lt;
  logic       cond_taken;
  logic       cond_illegal;
  logic       load;
  logic       out_valid_q;
  br_result_t res_d;
  br_result_t res_q;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .a         (a),
    .b         (b),
    .funct3    (funct3),
    .is_branch (is_branch),
    .eq        (cond_eq),
    .lt        (cond_lt),
    .taken     (cond_taken),
    .illegal   (cond_illegal)
  );

  // eq/lt pass through ungated so an idle slot still holds a
  // deterministic value; everything with a side effect is gated by in_valid.
  always_comb begin
    res_d.eq         = cond_eq;
    res_d.lt         = cond_lt;
    res_d.taken      = in_valid & cond_taken;
    res_d.illegal    = in_valid & cond_illegal;
    res_d.mispredict = in_valid & (cond_taken ^ pred_taken);
  end

  assign load = !flush && !stall;

  // Flush only drops the valid bit; the stale result is harmless
  // because consumers qualify it with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= in_valid;
      res_q       <= res_d;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  // Counters only advance on edges that actually load a result, and stick
  // at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (load) begin
      if (in_valid && is_branch && (br_cnt_q != '1))
        br_cnt_q <= br_cnt_q + 1'b1;
      if (res_d.mispredict && (mis_cnt_q != '1))
        mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`else
  logic unused_load;
  localparam int unused_cnt_w = CNT_W;
  assign unused_load = load;
`endif

  assign out_valid  = out_valid_q;
  assign eq         = res_q.eq;
  assign lt         = res_q.lt;
  assign taken      = res_q.taken;
  assign mispredict = res_q.mispredict;
  assign illegal    = res_q.illegal;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit: a table of single-cycle
// vectors plus hand-written stall/flush/reset/counter sequences.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
`ifdef BRU_PERF_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 32;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             is_branch;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic             pred_taken;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic             eq;
  logic             lt;
  logic             taken;
  logic             mispredict;
  logic             illegal;
`ifdef BRU_PERF_CNT_EN
  logic             clr_cnt;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .is_branch  (is_branch),
    .funct3     (funct3),
    .a          (a),
    .b          (b),
    .pred_taken (pred_taken),
    .stall      (stall),
    .flush      (flush),
`ifdef BRU_PERF_CNT_EN
    .clr_cnt    (clr_cnt),
    .br_cnt     (br_cnt),
    .mis_cnt    (mis_cnt),
`endif
    .out_valid  (out_valid),
    .eq         (eq),
    .lt         (lt),
    .taken      (taken),
    .mispredict (mispredict),
    .illegal    (illegal)
  );

  // One directed vector: inputs plus expected {out_valid,eq,lt,taken,mispredict,illegal}.
  typedef struct {
    logic            in_valid;
    logic            is_branch;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            pred_taken;
    logic [5:0]      expected;
  } vec_t;

  vec_t vecs[16];

  // Drives one set of inputs; called just after a falling edge.
  task automatic applyStimulus(input logic v, input logic br, input logic [2:0] f3,
                               input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                               input logic pt);
    in_valid   = v;
    is_branch  = br;
    funct3     = f3;
    a          = av;
    b          = bv;
    pred_taken = pt;
  endtask

  // Compares one observed value with its expected value and logs a failure.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Lets one rising edge pass and returns at the following falling edge.
  task automatic nextCycle();
    @(negedge clk);
  endtask

  function automatic logic [63:0] outBits();
    return {58'd0, out_valid, eq, lt, taken, mispredict, illegal};
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 6'b101110};
    vecs[1]  = '{1'b1, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 6'b100000};
    vecs[2]  = '{1'b1, 1'b1, 3'b101, 32'h1234_5678, 32'h1234_5678, 1'b0, 6'b110110};
    vecs[3]  = '{1'b1, 1'b1, 3'b001, 32'h1234_5678, 32'h1234_5678, 1'b1, 6'b110010};
    vecs[4]  = '{1'b1, 1'b1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 6'b101100};
    vecs[5]  = '{1'b1, 1'b1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 6'b100010};
    vecs[6]  = '{1'b1, 1'b1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 6'b101000};
    vecs[7]  = '{1'b1, 1'b1, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 6'b100110};
    vecs[8]  = '{1'b1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 6'b101100};
    vecs[9]  = '{1'b1, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 6'b100000};
    vecs[10] = '{1'b1, 1'b1, 3'b111, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 6'b101010};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_0001, 32'h0000_0001, 1'b0, 6'b110001};
    vecs[12] = '{1'b1, 1'b1, 3'b011, 32'h0000_0005, 32'h0000_0003, 1'b1, 6'b100011};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000, 1'b1, 6'b110010};
    vecs[14] = '{1'b0, 1'b1, 3'b000, 32'h0000_0007, 32'h0000_0007, 1'b1, 6'b010000};
    vecs[15] = '{1'b1, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_0003, 1'b0, 6'b110110};

    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
`ifdef BRU_PERF_CNT_EN
    clr_cnt = 1'b0;
`endif
    applyStimulus(1'b1, 1'b1, 3'b000, 32'd1, 32'd1, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("reset_outputs", outBits(), 64'd0);
`ifdef BRU_PERF_CNT_EN
    checkOutput("reset_br_cnt", 64'(br_cnt), 64'd0);
    checkOutput("reset_mis_cnt", 64'(mis_cnt), 64'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].is_branch, vecs[i].funct3,
                    vecs[i].a, vecs[i].b, vecs[i].pred_taken);
      nextCycle();
      checkOutput($sformatf("vec%0d", i), outBits(), {58'd0, vecs[i].expected});
    end

    // Stall holds a taken BEQ for three cycles despite new inputs.
    applyStimulus(1'b1, 1'b1, 3'b000, 32'd9, 32'd9, 1'b1);
    nextCycle();
    checkOutput("stall_preload", outBits(), 64'b110100);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 3'b001, 32'd1, 32'd2 + 32'(i), 1'b0);
      nextCycle();
      checkOutput($sformatf("stall_hold%0d", i), outBits(), 64'b110100);
    end
    flush = 1'b1;
    nextCycle();
    checkOutput("stall_flush_valid", 64'(out_valid), 64'd0);
    stall = 1'b0;
    flush = 1'b0;

    // Reset during a stall clears a live taken result.
    applyStimulus(1'b1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
    nextCycle();
    checkOutput("prereset_load", outBits(), 64'b101100);
    stall = 1'b1;
    rst   = 1'b1;
    nextCycle();
    checkOutput("reset_mid_stall", outBits(), 64'd0);
`ifdef BRU_PERF_CNT_EN
    checkOutput("reset_mid_stall_br_cnt", 64'(br_cnt), 64'd0);
    checkOutput("reset_mid_stall_mis_cnt", 64'(mis_cnt), 64'd0);
`endif
    rst   = 1'b0;
    stall = 1'b0;

`ifdef BRU_PERF_CNT_EN
    // Five mispredicting BNE-not-taken loads separated by stalls saturate at 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 3'b001, 32'd4, 32'd4, 1'b1);
      stall = 1'b0;
      nextCycle();
      stall = 1'b1;
      nextCycle();
    end
    stall = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    checkOutput("sat_br_cnt", 64'(br_cnt), 64'd3);
    checkOutput("sat_mis_cnt", 64'(mis_cnt), 64'd3);
    clr_cnt = 1'b1;
    nextCycle();
    clr_cnt = 1'b0;
    checkOutput("clr_br_cnt", 64'(br_cnt), 64'd0);
    checkOutput("clr_mis_cnt", 64'(mis_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
